// File: rtl/line_to_word_fifo_if.sv
// Handshake bundle for line_to_word_fifo: line write side, word read side,
// synchronous clear and status outputs. The master drives writes/reads,
// the slave (the FIFO) drives the read data and status.
interface line_to_word_fifo_if #(
    parameter int LINE_W      = 512,
    parameter int WORD_W      = 64,
    parameter int DEPTH_LINES = 8
);
    localparam int RATIO = LINE_W / WORD_W;
    localparam int CW    = $clog2(RATIO) + 1;
    localparam int LW    = $clog2(DEPTH_LINES) + 1;

    logic              clr;
    logic              wr_en;
    logic [LINE_W-1:0] wr_data;
    logic [CW-1:0]     wr_words;
    logic              rd_en;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, wr_en, wr_data, wr_words, rd_en,
        input  rd_data, rd_valid, rd_last, empty, full, almost_full,
               level, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, wr_data, wr_words, rd_en,
        output rd_data, rd_valid, rd_last, empty, full, almost_full,
               level, overflow, underflow
    );
endinterface

// File: rtl/line_to_word_fifo.sv
// Wide-to-narrow width-converting FIFO. Cache lines are written whole and
// read back one WORD_W word per pop, word 0 first (little-endian order).
// Optional feature macro: LINE_TO_WORD_PARTIAL_EN -- when defined, each line
// carries its own word count (wr_words, clamped to 1..RATIO); when undefined
// every line holds RATIO words and wr_words is ignored.
module line_to_word_fifo #(
    parameter int LINE_W       = 512,
    parameter int WORD_W       = 64,
    parameter int DEPTH_LINES  = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                clk,
    input  logic                reset,
    line_to_word_fifo_if.slave  io_bus
);
    localparam int RATIO = LINE_W / WORD_W;
    localparam int AW    = $clog2(DEPTH_LINES);
    localparam int PW    = AW + 1;
    localparam int IW    = $clog2(RATIO);
    localparam int CW    = IW + 1;
    localparam int LW    = AW + 1;

    logic [LINE_W-1:0] r_mem [DEPTH_LINES];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [IW-1:0]     r_word_idx;
    logic [LW-1:0]     r_level;
    logic [WORD_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_last;
    logic              r_empty;
    logic              r_full;
    logic              r_afull;
    logic              r_overflow;
    logic              r_underflow;

    logic                         w_wr_acc;
    logic                         w_rd_acc;
    logic                         w_line_done;
    logic [CW-1:0]                w_head_cnt;
    logic [RATIO-1:0][WORD_W-1:0] w_head_line;
    logic [WORD_W-1:0]            w_head_word;
    logic [PW-1:0]                w_wr_ptr_nxt;
    logic [PW-1:0]                w_rd_ptr_nxt;
    logic [LW-1:0]                w_level_nxt;
    logic                         w_full_nxt;
    logic                         w_empty_nxt;
    logic                         w_afull_nxt;

`ifdef LINE_TO_WORD_PARTIAL_EN
    logic [CW-1:0] r_cnt [DEPTH_LINES];

    // Out-of-range word counts (0 or above RATIO) mean a full line.
    function automatic logic [CW-1:0] clamp_words(input logic [CW-1:0] words);
        if ((words == CW'(0)) || (words > CW'(RATIO))) begin
            return CW'(RATIO);
        end else begin
            return words;
        end
    endfunction

    // Per-line word count is stored alongside the line data.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_cnt[r_wr_ptr[AW-1:0]] <= clamp_words(io_bus.wr_words);
        end
    end

    // Word count of the line currently at the head.
    always_comb begin
        w_head_cnt = r_cnt[r_rd_ptr[AW-1:0]];
    end
`else
    logic w_unused_words;
    assign w_unused_words = ^io_bus.wr_words;
    assign w_head_cnt     = CW'(RATIO);
`endif

    // Line storage; contents need no reset because level/empty gate every read.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[AW-1:0]] <= io_bus.wr_data;
        end
    end

    // Accept/pop decisions, head word select and next-state occupancy.
    always_comb begin
        // A full FIFO refuses writes even if the head line frees this cycle.
        w_wr_acc     = io_bus.wr_en && !r_full;
        w_rd_acc     = io_bus.rd_en && !r_empty;
        w_head_line  = r_mem[r_rd_ptr[AW-1:0]];
        w_head_word  = w_head_line[r_word_idx];
        w_line_done  = w_rd_acc && ({1'b0, r_word_idx} == (w_head_cnt - CW'(1)));
        w_wr_ptr_nxt = r_wr_ptr + (w_wr_acc ? PW'(1) : PW'(0));
        w_rd_ptr_nxt = r_rd_ptr + (w_line_done ? PW'(1) : PW'(0));
        if (w_wr_acc && !w_line_done) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_wr_acc && w_line_done) begin
            w_level_nxt = r_level - LW'(1);
        end else begin
            w_level_nxt = r_level;
        end
        w_full_nxt  = (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                      (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);
        w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
        w_afull_nxt = (w_level_nxt >= LW'(AFULL_THRESH));
    end

    // Pointers, word index, read output register, status flags and sticky errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= PW'(0);
            r_rd_ptr    <= PW'(0);
            r_word_idx  <= IW'(0);
            r_level     <= LW'(0);
            r_rd_data   <= WORD_W'(0);
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_afull     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (io_bus.clr) begin
            r_wr_ptr    <= PW'(0);
            r_rd_ptr    <= PW'(0);
            r_word_idx  <= IW'(0);
            r_level     <= LW'(0);
            r_rd_data   <= WORD_W'(0);
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_afull     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_empty  <= w_empty_nxt;
            r_full   <= w_full_nxt;
            r_afull  <= w_afull_nxt;
            if (w_rd_acc) begin
                r_rd_data  <= w_head_word;
                r_rd_valid <= 1'b1;
                r_rd_last  <= w_line_done;
                r_word_idx <= w_line_done ? IW'(0) : (r_word_idx + IW'(1));
            end else begin
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end
            if (io_bus.wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            if (io_bus.rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign io_bus.rd_data     = r_rd_data;
    assign io_bus.rd_valid    = r_rd_valid;
    assign io_bus.rd_last     = r_rd_last;
    assign io_bus.empty       = r_empty;
    assign io_bus.full        = r_full;
    assign io_bus.almost_full = r_afull;
    assign io_bus.level       = r_level;
    assign io_bus.overflow    = r_overflow;
    assign io_bus.underflow   = r_underflow;
endmodule

// File: tb/tb_line_to_word_fifo.sv
// Self-checking bench for line_to_word_fifo: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// queue-based word model.
module tb_line_to_word_fifo;
    localparam int LINE_W = 512;
    localparam int WORD_W = 64;
    localparam int DEPTH  = 8;
    localparam int AFULL  = 6;
    localparam int RATIO  = LINE_W / WORD_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_to_word_fifo_if #(.LINE_W(LINE_W), .WORD_W(WORD_W), .DEPTH_LINES(DEPTH)) bus ();

    line_to_word_fifo #(
        .LINE_W(LINE_W), .WORD_W(WORD_W), .DEPTH_LINES(DEPTH), .AFULL_THRESH(AFULL)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .io_bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a queue of words ----------------
    logic [63:0] wq[$];
    bit          lq[$];
    int          m_lines = 0;
    logic [63:0] m_data  = 64'h0;
    bit          m_valid = 1'b0;
    bit          m_last  = 1'b0;
    bit          m_ovf   = 1'b0;
    bit          m_unf   = 1'b0;
    bit          was_full, was_empty;
    int          n_words;

    function automatic int line_cnt(input logic [3:0] ww);
`ifdef LINE_TO_WORD_PARTIAL_EN
        if (ww == 4'd0 || ww > 4'(RATIO)) return RATIO;
        return int'(ww);
`else
        return RATIO;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || bus.clr) begin
            wq.delete(); lq.delete();
            m_lines = 0; m_data = 64'h0; m_valid = 1'b0; m_last = 1'b0;
            m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            was_full  = (m_lines == DEPTH);
            was_empty = (wq.size() == 0);
            m_valid = 1'b0;
            m_last  = 1'b0;
            if (bus.rd_en) begin
                if (was_empty) m_unf = 1'b1;
                else begin
                    m_data  = wq.pop_front();
                    m_last  = lq.pop_front();
                    m_valid = 1'b1;
                    if (m_last) m_lines--;
                end
            end
            if (bus.wr_en) begin
                if (was_full) m_ovf = 1'b1;
                else begin
                    n_words = line_cnt(bus.wr_words);
                    for (int k = 0; k < n_words; k++) begin
                        wq.push_back(bus.wr_data[k*64 +: 64]);
                        lq.push_back(k == n_words - 1);
                    end
                    m_lines++;
                end
            end
        end
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        chk("rd_valid",    64'(bus.rd_valid),    64'(m_valid));
        chk("rd_data",     bus.rd_data,          m_data);
        chk("rd_last",     64'(bus.rd_last),     64'(m_last));
        chk("level",       64'(bus.level),       64'(m_lines));
        chk("full",        64'(bus.full),        64'(m_lines == DEPTH));
        chk("almost_full", 64'(bus.almost_full), 64'(m_lines >= AFULL));
        chk("empty",       64'(bus.empty),       64'(wq.size() == 0));
        chk("overflow",    64'(bus.overflow),    64'(m_ovf));
        chk("underflow",   64'(bus.underflow),   64'(m_unf));
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [511:0] pat_line(input logic [63:0] base);
        logic [511:0] l;
        for (int k = 0; k < RATIO; k++) l[k*64 +: 64] = base + 64'(k);
        return l;
    endfunction

    task automatic cycle(input bit wr, input logic [511:0] d, input logic [3:0] ww, input bit rd);
        bus.wr_en    = wr;
        bus.wr_data  = d;
        bus.wr_words = ww;
        bus.rd_en    = rd;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
    endtask

    task automatic scen1();
        cycle(1'b1, pat_line(64'h1000), 4'd8, 1'b0);
        chk("s1_empty_after_write", 64'(bus.empty), 64'h0);
        for (int k = 0; k < RATIO; k++) begin
            cycle(1'b0, '0, 4'd0, 1'b1);
            chk("s1_valid", 64'(bus.rd_valid), 64'h1);
            chk("s1_data",  bus.rd_data, 64'h1000 + 64'(k));
            chk("s1_last",  64'(bus.rd_last), 64'(k == RATIO - 1));
        end
        chk("s1_empty_end", 64'(bus.empty), 64'h1);
        chk("s1_level_end", 64'(bus.level), 64'h0);
    endtask

    initial begin
        bus.clr = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        bus.wr_data = '0; bus.wr_words = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_empty", 64'(bus.empty), 64'h1);
        chk("rst_level", 64'(bus.level), 64'h0);
        chk("rst_valid", 64'(bus.rd_valid), 64'h0);
        chk("rst_data",  bus.rd_data, 64'h0);
        chk("rst_full",  64'(bus.full), 64'h0);

        // Scenario 1: one pattern line, eight pops in order.
        scen1();

        // Scenario 2: fill to full, overflow, drain.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, rand_line(), 4'd8, 1'b0);
            chk("s2_afull", 64'(bus.almost_full), 64'(i >= AFULL));
            chk("s2_level", 64'(bus.level), 64'(i));
        end
        chk("s2_full", 64'(bus.full), 64'h1);
        cycle(1'b1, rand_line(), 4'd8, 1'b0);
        chk("s2_overflow", 64'(bus.overflow), 64'h1);
        chk("s2_level_after_drop", 64'(bus.level), 64'h8);
        for (int i = 0; i < DEPTH * RATIO; i++) cycle(1'b0, '0, 4'd0, 1'b1);
        chk("s2_empty", 64'(bus.empty), 64'h1);

        // Scenario 3: write while full coinciding with final-word pop.
        do_clr();
        chk("s3_clr_overflow", 64'(bus.overflow), 64'h0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_line(), 4'd8, 1'b0);
        for (int i = 0; i < RATIO - 1; i++) cycle(1'b0, '0, 4'd0, 1'b1);
        cycle(1'b1, rand_line(), 4'd8, 1'b1);
        chk("s3_overflow", 64'(bus.overflow), 64'h1);
        chk("s3_level", 64'(bus.level), 64'h7);
        chk("s3_last",  64'(bus.rd_last), 64'h1);
        for (int i = 0; i < 7 * RATIO; i++) cycle(1'b0, '0, 4'd0, 1'b1);

        // Scenario 4: underflow, then randomized interleaved traffic.
        do_clr();
        cycle(1'b0, '0, 4'd0, 1'b1);
        chk("s4_underflow", 64'(bus.underflow), 64'h1);
        chk("s4_valid", 64'(bus.rd_valid), 64'h0);
        for (int c = 0; c < 300; c++)
            cycle($urandom_range(0, 99) < 30, rand_line(), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 70);
        for (int c = 0; c < 300; c++)
            cycle($urandom_range(0, 99) < 10, rand_line(), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 85);
        for (int c = 0; c < 80; c++) cycle(1'b0, '0, 4'd0, 1'b1);
        chk("s4_drained", 64'(bus.empty), 64'h1);

`ifdef LINE_TO_WORD_PARTIAL_EN
        // Scenario 5: partial line of 3 words, then wr_words=0 meaning a full line.
        do_clr();
        cycle(1'b1, pat_line(64'h2000), 4'd3, 1'b0);
        cycle(1'b1, pat_line(64'h3000), 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, '0, 4'd0, 1'b1);
            chk("s5_data_a", bus.rd_data, 64'h2000 + 64'(k));
            chk("s5_last_a", 64'(bus.rd_last), 64'(k == 2));
        end
        for (int k = 0; k < RATIO; k++) begin
            cycle(1'b0, '0, 4'd0, 1'b1);
            chk("s5_data_b", bus.rd_data, 64'h3000 + 64'(k));
            chk("s5_last_b", 64'(bus.rd_last), 64'(k == RATIO - 1));
        end
`endif

        // Scenario 6: asynchronous reset mid-line with three lines stored.
        do_clr();
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_line(), 4'd8, 1'b0);
        cycle(1'b0, '0, 4'd0, 1'b1);
        cycle(1'b0, '0, 4'd0, 1'b1);
        bus.rd_en = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("s6_level", 64'(bus.level), 64'h0);
        chk("s6_empty", 64'(bus.empty), 64'h1);
        chk("s6_valid", 64'(bus.rd_valid), 64'h0);
        chk("s6_data",  bus.rd_data, 64'h0);
        chk("s6_full",  64'(bus.full), 64'h0);
        bus.rd_en = 1'b0;
        @(posedge clk);
        #1;
        chk("s6_valid_suppressed", 64'(bus.rd_valid), 64'h0);
        rst = 1'b0;
        scen1();

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
